// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory controller: FSM states,
// access size codes and the bit positions inside sign_mask.
package data_mem_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    READ_BUFFER = 3'd1,
    READ        = 3'd2,
    WRITE       = 3'd3,
    FAULT       = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int SM_SIGN    = 3;
  localparam int SM_SIZE_HI = 2;
  localparam int SM_SIZE_LO = 1;

endpackage

// File: rtl/data_mem_lane_align.sv
// Combinational lane logic: picks the addressed byte/half out of a word for
// loads (with optional sign extension) and merges store data into a word.
module data_mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] write_data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  lane_en;
  logic [31:0] store_rep;

  always_comb begin
    byte_sel  = word[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? word[31:16] : word[15:0];
    load_data = word;
    lane_en   = 4'b1111;
    store_rep = write_data;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        lane_en   = 4'b0001 << lane;
        store_rep = {4{write_data[7:0]}};
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
        lane_en   = lane[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Store data is replicated across lanes so each lane just chooses old or new.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign store_word[8*gi +: 8] = lane_en[gi] ? store_rep[8*gi +: 8] : word[8*gi +: 8];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: buffers one load/store, classifies it, then runs a
// read-modify-write against a synchronous-read RAM or the LED register.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int          ADDR_W      = 14,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000,
  parameter logic [31:0] LED_ADDR    = 32'h2000,
  parameter int          LED_W       = 8,
  parameter string       INIT_FILE   = "programs/data.hex"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [3:0]        sign_mask,
  output logic [31:0]       read_data,
  output logic              clk_stall,
  output logic              fault,
  output logic [LED_W-1:0]  led
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:1]        mask_reg;
  logic              rd_reg, wr_reg;
  logic [31:0]       read_data_reg;
  logic [LED_W-1:0]  led_reg;

  logic [31:0]       ram [DEPTH_WORDS];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  ram_idx;
  logic              ram_we;

  logic [1:0]  size;
  logic        led_hit, ram_hit, misaligned, access_bad;
  logic [31:0] word_buf, load_data, store_word;
  logic        unused_bits;

  // Request buffers follow the inputs while idle and freeze during an access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      mask_reg  <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
    end else if (state_reg == IDLE) begin
      addr_reg  <= addr;
      wdata_reg <= write_data;
      mask_reg  <= sign_mask[3:1];
      rd_reg    <= memread;
      wr_reg    <= memwrite;
    end
  end

  assign size       = mask_reg[SM_SIZE_HI:SM_SIZE_LO];
  assign offset     = addr_reg - BASE_A;
  assign ram_idx    = offset[IDX_W+1:2];
  assign led_hit    = 32'(addr_reg) == LED_ADDR;
  assign ram_hit    = (32'(addr_reg) >= BASE_ADDR) &&
                      (32'(addr_reg) <  BASE_ADDR + 32'(4 * DEPTH_WORDS));
  assign misaligned = ((size == SZ_HALF) && addr_reg[0]) ||
                      ((size == SZ_WORD) && (addr_reg[1:0] != 2'b00));
  assign access_bad = misaligned || (size == 2'b10) || !(led_hit || ram_hit) ||
                      (rd_reg && wr_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:        state_next = (memread || memwrite) ? READ_BUFFER : IDLE;
      READ_BUFFER: state_next = access_bad ? FAULT : (rd_reg ? READ : WRITE);
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    clk_stall = 1'b0;
    fault     = 1'b0;
    case (state_reg)
      READ_BUFFER, READ, WRITE: clk_stall = 1'b1;
      FAULT:                    fault     = 1'b1;
      default: ;
    endcase
  end

  // ram_q captures the addressed word on the edge leaving READ_BUFFER.
  assign word_buf = led_hit ? 32'(led_reg) : ram_q;
  assign ram_we   = (state_reg == WRITE) && !led_hit;

  data_mem_lane_align u_lane_align (
    .word       (word_buf),
    .write_data (wdata_reg),
    .lane       (addr_reg[1:0]),
    .size       (size),
    .sign_ext   (mask_reg[SM_SIGN]),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= store_word;
    ram_q <= ram[ram_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_reg <= '0;
      led_reg       <= '0;
    end else begin
      if (state_reg == READ) read_data_reg <= load_data;
      if ((state_reg == WRITE) && led_hit) led_reg <= wdata_reg[LED_W-1:0];
    end
  end

  assign read_data = read_data_reg;
  assign led       = led_reg;

  // The preload image is attached by the device memory-init flow, not by RTL.
  assign unused_bits = ^{offset[ADDR_W-1:IDX_W+2], offset[1:0], sign_mask[0],
                         (INIT_FILE != "")};

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: drives single accesses, keeps expected
// load results in a scoreboard queue and checks stall/fault/latency per access.
module tb_data_mem_ctrl;

  localparam logic [3:0] M_WORD  = 4'b0110;
  localparam logic [3:0] M_HALFU = 4'b0010;
  localparam logic [3:0] M_HALFS = 4'b1010;
  localparam logic [3:0] M_BYTEU = 4'b0000;
  localparam logic [3:0] M_BYTES = 4'b1000;
  localparam logic [3:0] M_SZ10  = 4'b0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] addr;
  logic [31:0] write_data;
  logic        memwrite, memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall, fault;
  logic [7:0]  led;

  int total = 0;
  int bad   = 0;
  logic [31:0] expq[$];
  logic [31:0] rd_model = '0;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .sign_mask  (sign_mask),
    .read_data  (read_data),
    .clk_stall  (clk_stall),
    .fault      (fault),
    .led        (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access: drive for one cycle, then sample four cycles after acceptance.
  task automatic access(input logic rd, input logic wr, input logic [13:0] a,
                        input logic [31:0] wd, input logic [3:0] sm,
                        input bit is_bad, input logic [31:0] exp_rd);
    int st;
    int ft;
    logic [31:0] exp;
    if (rd && !is_bad) expq.push_back(exp_rd);
    @(negedge clk);
    memread = rd; memwrite = wr; addr = a; write_data = wd; sign_mask = sm;
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
    st = 0; ft = 0;
    for (int i = 0; i < 4; i++) begin
      st += int'(clk_stall);
      ft += int'(fault);
      if (i == 1) check("latency_hold", read_data, rd_model);
      if (i == 2) begin
        if (rd && !is_bad) begin
          exp = expq.pop_front();
          check("load_data", read_data, exp);
          rd_model = exp;
        end else begin
          check("rdata_kept", read_data, rd_model);
        end
      end
      @(posedge clk); #1;
    end
    check("stall_cycles", 32'(st), is_bad ? 32'd1 : 32'd2);
    check("fault_pulses", 32'(ft), is_bad ? 32'd1 : 32'd0);
    $display("access rd=%0b wr=%0b addr=%h wdata=%h mask=%b read_data=%h led=%h",
             rd, wr, a, wd, sm, read_data, led);
  endtask

  initial begin
    rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0;
    addr = '0; write_data = '0; sign_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 32'(clk_stall), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // word round trip
    access(0, 1, 14'h1004, 32'hDEADBEEF, M_WORD, 0, '0);
    access(1, 0, 14'h1004, '0, M_WORD, 0, 32'hDEADBEEF);

    // byte store into a known word, then signed/unsigned/word reads
    access(0, 1, 14'h1004, 32'h11223344, M_WORD, 0, '0);
    access(0, 1, 14'h1006, 32'h00000080, M_BYTEU, 0, '0);
    access(1, 0, 14'h1006, '0, M_BYTES, 0, 32'hFFFFFF80);
    access(1, 0, 14'h1006, '0, M_BYTEU, 0, 32'h00000080);
    access(1, 0, 14'h1004, '0, M_WORD, 0, 32'h11803344);

    // request held high: not re-accepted in the cycle READ returns to IDLE
    expq.push_back(32'h11803344);
    @(negedge clk);
    memread = 1'b1; addr = 14'h1004; sign_mask = M_WORD;
    @(posedge clk); #1; check("b2b_accept", 32'(clk_stall), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1; check("b2b_gap", 32'(clk_stall), 32'd0);
    rd_model = expq.pop_front();
    check("b2b_data", read_data, rd_model);
    @(posedge clk); #1; check("b2b_next", 32'(clk_stall), 32'd1);
    memread = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; check("b2b_done", 32'(clk_stall), 32'd0);
    check("b2b_data2", read_data, rd_model);
    $display("access b2b addr=1004 read_data=%h", read_data);

    // half-word accesses and a misaligned half
    access(0, 1, 14'h1000, 32'hCAFE1234, M_WORD, 0, '0);
    access(1, 0, 14'h1002, '0, M_HALFU, 0, 32'h0000CAFE);
    access(1, 0, 14'h1001, '0, M_HALFU, 1, '0);
    access(1, 0, 14'h1000, '0, M_WORD, 0, 32'hCAFE1234);
    access(1, 0, 14'h1002, '0, M_HALFS, 0, 32'hFFFFCAFE);
    access(1, 0, 14'h1000, '0, M_HALFS, 0, 32'h00001234);

    // other rejected accesses
    access(1, 0, 14'h1002, '0, M_WORD, 1, '0);
    access(1, 0, 14'h1000, '0, M_SZ10, 1, '0);
    access(1, 1, 14'h1000, 32'h55555555, M_WORD, 1, '0);
    access(1, 0, 14'h1000, '0, M_WORD, 0, 32'hCAFE1234);

    // LED register and an unmapped store
    access(0, 1, 14'h2000, 32'h000000A5, M_WORD, 0, '0);
    check("led_set", 32'(led), 32'h000000A5);
    access(1, 0, 14'h2000, '0, M_WORD, 0, 32'h000000A5);
    access(0, 1, 14'h0FFC, 32'hFFFFFF33, M_WORD, 1, '0);
    check("led_kept", 32'(led), 32'h000000A5);

    // top word: byte lane 3 updates, no wrap to word 0
    access(0, 1, 14'h1FFC, 32'h01020304, M_WORD, 0, '0);
    access(0, 1, 14'h1FFF, 32'h0000005A, M_BYTEU, 0, '0);
    access(1, 0, 14'h1FFC, '0, M_WORD, 0, 32'h5A020304);
    access(1, 0, 14'h1000, '0, M_WORD, 0, 32'hCAFE1234);
    access(1, 0, 14'h1FFF, '0, M_BYTEU, 0, 32'h0000005A);

    // reset during WRITE aborts the store
    access(0, 1, 14'h1008, 32'hA0A0A0A0, M_WORD, 0, '0);
    @(negedge clk);
    memwrite = 1'b1; addr = 14'h1008; write_data = 32'h12345678; sign_mask = M_WORD;
    @(posedge clk); #1; memwrite = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_stall", 32'(clk_stall), 32'd0);
    check("abort_led", 32'(led), 32'd0);
    check("abort_rdata", read_data, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    rd_model = '0;
    $display("access reset-abort addr=1008 wdata=12345678");
    access(1, 0, 14'h1008, '0, M_WORD, 0, 32'hA0A0A0A0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ADDR_W, 14, byte address width
- DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two)
- BASE_ADDR, 'h1000, byte address of RAM word 0
- LED_ADDR, 'h2000, byte address of the LED register
- LED_W, 8, LED register width
- INIT_FILE, "programs/data.hex", RAM preload image
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- addr  in  ADDR_W  byte address
- write_data  in  32  store data, right-justified
- memwrite  in  1  store request
- memread  in  1  load request
- sign_mask  in  4  [3]=sign-extend; [2:1]=size (00 byte, 01 half, 11 word); [0] reserved
- read_data  out  32  load result
- clk_stall  out  1  core stall while an access is in flight
- fault  out  1  one-cycle pulse on a rejected access
- led  out  LED_W  LED register
REQ-003 The clock SHALL be named clk and the reset rst_n, with one clock, asynchronous active-low reset.

Function
REQ-004 States SHALL be IDLE, READ_BUFFER, READ, WRITE, FAULT; all other encodings return to IDLE.
REQ-005 In IDLE, addr, write_data, sign_mask, memread and memwrite SHALL be registered every cycle; if memread|memwrite, go to READ_BUFFER and assert clk_stall next cycle.
REQ-006 READ_BUFFER SHALL classify the access: misaligned (half with addr[0]=1, word with addr[1:0]!=0), unmapped (not LED_ADDR and not BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS), size 10, or memread&memwrite both set -> FAULT; else load word (RAM[(addr-BASE_ADDR)>>2] or zero-extended led) into word buffer and go to READ (load) or WRITE (store).
REQ-007 READ SHALL drive read_data with the selected byte/half/word, sign- or zero-extended per sign_mask[3], deassert clk_stall, return to IDLE; load latency = 3 cycles from accepting edge to read_data valid.
REQ-008 WRITE SHALL merge write_data into the buffered word on the addressed lane(s) only (byte: lane addr[1:0]; half: lanes by addr[1]; word: all), write it back, deassert clk_stall, return to IDLE.
REQ-009 A store to LED_ADDR SHALL update led with write_data[LED_W-1:0] in WRITE regardless of size; RAM SHALL be untouched.
REQ-010 FAULT SHALL pulse fault for one cycle, deassert clk_stall, leave RAM, led and read_data unchanged, return to IDLE.
REQ-011 A request present in the cycle a READ/WRITE/FAULT state returns to IDLE SHALL NOT be accepted until the following IDLE cycle (no back-to-back acceptance).
REQ-012 Byte and half accesses at the top word (index DEPTH_WORDS-1) SHALL be legal; index SHALL NOT wrap.

Reset
REQ-013 While rst_n=0: state=IDLE, clk_stall=0, fault=0, read_data=0, led=0, all request buffers cleared.
REQ-014 Reset asserted mid-access SHALL abort it; a pending WRITE SHALL NOT modify RAM; RAM contents SHALL be retained (only INIT_FILE preload at configuration).

Structure
REQ-015 Package data_mem_pkg SHALL hold the state enum, size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and sign_mask bit indices.
REQ-016 Lane extraction/sign-extension and store merge SHALL be one combinational sub-module, data_mem_lane_align; RAM SHALL be one synchronous-read array inferable as block RAM.

Verification
REQ-017 Word store 0xDEADBEEF to 0x1004, then word load 0x1004 -> read_data=0xDEADBEEF 3 cycles after load accept; clk_stall high exactly 2 cycles per access.
REQ-018 Byte store 0x80 to 0x1006 over 0x11223344, then signed byte load 0x1006 -> 0xFFFFFF80, unsigned -> 0x00000080, word load -> 0x11803344.
REQ-019 Unsigned half load 0x1002 of 0xCAFE1234 -> 0x0000CAFE; half load 0x1001 -> fault pulse, read_data unchanged, RAM unchanged.
REQ-020 Word store 0x000000A5 to 0x2000 -> led=0xA5; load 0x2000 -> 0x000000A5; store to 0x0FFC -> fault, led and RAM unchanged.
REQ-021 rst_n low in WRITE cycle of store 0x12345678 to 0x1008 -> word at 0x1008 keeps old value, clk_stall=0, led=0.
REQ-022 memread=memwrite=1 to 0x1000 -> fault pulse; byte store to 0x1FFF then read -> lane 3 of top word updated, no wrap to 0x1000.
